// File: rtl/dma_burst_ctrl_if.sv
// Command/status bundle between a DMA host/AXI-HP adapter and dma_burst_ctrl.
// master = host/adapter side, slave = burst controller side.
interface dma_burst_ctrl_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BURST_LOG2 = 7,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned BA_W = ADDR_W - BURST_LOG2;

  logic [BA_W-1:0]  mem_address;
  logic [CNT_W-1:0] sector_cnt;
  logic             dma_type;
  logic             dma_start;
  logic             dma_abort;
  logic             dma_busy;
  logic             dma_done;
  logic             dma_aborted;
  logic [BA_W-1:0]  cmd_addr;
  logic             cmd_dir;
  logic             cmd_val;
  logic             cmd_ack;
  logic             burst_done;
  logic             buf_rdy;

  modport master (
    output mem_address, sector_cnt, dma_type, dma_start, dma_abort,
    output cmd_ack, burst_done, buf_rdy,
    input  dma_busy, dma_done, dma_aborted, cmd_addr, cmd_dir, cmd_val
  );

  modport slave (
    input  mem_address, sector_cnt, dma_type, dma_start, dma_abort,
    input  cmd_ack, burst_done, buf_rdy,
    output dma_busy, dma_done, dma_aborted, cmd_addr, cmd_dir, cmd_val
  );
endinterface

// File: rtl/dma_burst_ctrl.sv
// Splits a sector transfer into aligned fixed-size burst requests, throttled by the
// number of outstanding bursts and buffer readiness, and signals completion.
module dma_burst_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BURST_LOG2  = 7,
  parameter int unsigned SECTOR_LOG2 = 9,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_OUT     = 4
) (
  input logic            hclk,
  input logic            rst,
  dma_burst_ctrl_if.slave bus
);
  localparam int unsigned BA_W  = ADDR_W - BURST_LOG2;
  localparam int unsigned SHIFT = SECTOR_LOG2 - BURST_LOG2;
  localparam int unsigned REM_W = CNT_W + SHIFT;
  localparam int unsigned OUT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e           state_q;
  logic [BA_W-1:0]  addr_q;
  logic             dir_q;
  logic [REM_W-1:0] rem_q;
  logic [OUT_W-1:0] out_q;
  logic             abort_seen_q;
  logic             cmd_val_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;

  logic             accept;
  logic             can_issue;
  logic [REM_W-1:0] rem_d;
  logic [OUT_W-1:0] out_d;
  logic [REM_W-1:0] start_rem;

  // Outstanding/remaining counts as they will be after this edge; a simultaneous
  // accept and completion cancel, and a completion with nothing outstanding is dropped.
  always_comb begin
    accept    = cmd_val_q & bus.cmd_ack;
    out_d     = out_q;
    if (accept && !bus.burst_done) begin
      out_d = out_q + OUT_W'(1);
    end else if (!accept && bus.burst_done && (out_q != '0)) begin
      out_d = out_q - OUT_W'(1);
    end
    rem_d     = accept ? (rem_q - REM_W'(1)) : rem_q;
    can_issue = (rem_d != '0) && (out_d < OUT_W'(MAX_OUT)) && bus.buf_rdy && !bus.dma_abort;
    start_rem = REM_W'(bus.sector_cnt) << SHIFT;
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      dir_q        <= 1'b0;
      rem_q        <= '0;
      out_q        <= '0;
      abort_seen_q <= 1'b0;
      cmd_val_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      out_q  <= out_d;
      case (state_q)
        IDLE: begin
          // Start wins over a coincident abort; out_q is 0 here so the limit cannot block.
          if (bus.dma_start) begin
            addr_q       <= bus.mem_address;
            dir_q        <= bus.dma_type;
            rem_q        <= start_rem;
            busy_q       <= 1'b1;
            abort_seen_q <= 1'b0;
            aborted_q    <= 1'b0;
            if (bus.sector_cnt == '0) begin
              state_q <= DRAIN;
            end else begin
              state_q   <= ISSUE;
              cmd_val_q <= bus.buf_rdy;
            end
          end
        end
        ISSUE: begin
          rem_q <= rem_d;
          if (accept) begin
            addr_q <= addr_q + BA_W'(1);
          end
          if (bus.dma_abort) begin
            cmd_val_q    <= 1'b0;
            abort_seen_q <= 1'b1;
            state_q      <= DRAIN;
          end else if (accept && (rem_d == '0)) begin
            cmd_val_q <= 1'b0;
            state_q   <= DRAIN;
          end else if (!cmd_val_q || accept) begin
            cmd_val_q <= can_issue;
          end
        end
        DRAIN: begin
          if (bus.dma_abort) begin
            abort_seen_q <= 1'b1;
          end
          if (out_q == '0) begin
            state_q   <= DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= abort_seen_q | bus.dma_abort;
          end
        end
        DONE: begin
          aborted_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dma_busy    = busy_q;
  assign bus.dma_done    = done_q;
  assign bus.dma_aborted = aborted_q;
  assign bus.cmd_addr    = addr_q;
  assign bus.cmd_dir     = dir_q;
  assign bus.cmd_val     = cmd_val_q;
endmodule
